// File: rtl/fios_loop_ctrl_pkg.sv
// Shared types and timing formulas for the FIOS loop sequencer.
package fios_loop_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PROBE,
        MMWAIT,
        ISSUE,
        GAP
    } state_t;

    localparam int GAP_CYCLES = 2;

    // Controls that surface one cycle after their issue cycle.
    typedef struct packed {
        logic mm_load;
        logic carry_zero;
        logic d_last;
    } k1_ctl_t;

    // One i-iteration: probe, MM_LAT wait cycles, WORDS issues, then the gap.
    function automatic int iter_period(input int words, input int mm_lat);
        return words + mm_lat + 1 + GAP_CYCLES;
    endfunction

    // Cycles from start acceptance to the done pulse.
    function automatic int run_latency(input int words, input int mm_lat);
        return 1 + words * iter_period(words, mm_lat);
    endfunction

endpackage

// File: rtl/fios_ctrl_delay.sv
// Two-stage shift register aligning per-step controls from issue (k) to k+1 and k+2.
// Synchronous reset flushes both stages so no stale write-back survives a reset.
module fios_ctrl_delay
    import fios_loop_ctrl_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mm_load_k,
    input  logic             carry_zero_k,
    input  logic             d_last_k,
    input  logic             we_k,
    input  logic [IDX_W-1:0] waddr_k,
    input  logic             top_we_k,
    output logic             mm_load,
    output logic             carry_zero,
    output logic             d_last,
    output logic             t_we,
    output logic [IDX_W-1:0] t_waddr,
    output logic             t_top_we
);

    typedef struct packed {
        logic             we;
        logic [IDX_W-1:0] waddr;
        logic             top_we;
    } wb_ctl_t;

    k1_ctl_t s1_k1_q;
    wb_ctl_t s1_wb_q;
    wb_ctl_t s2_wb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_k1_q <= '0;
            s1_wb_q <= '0;
            s2_wb_q <= '0;
        end else begin
            s1_k1_q <= '{mm_load: mm_load_k, carry_zero: carry_zero_k, d_last: d_last_k};
            s1_wb_q <= '{we: we_k, waddr: waddr_k, top_we: top_we_k};
            s2_wb_q <= s1_wb_q;
        end
    end

    assign mm_load    = s1_k1_q.mm_load;
    assign carry_zero = s1_k1_q.carry_zero;
    assign d_last     = s1_k1_q.d_last;
    assign t_we       = s2_wb_q.we;
    assign t_waddr    = s2_wb_q.waddr;
    assign t_top_we   = s2_wb_q.top_we;

endmodule

// File: rtl/fios_loop_ctrl.sv
// FIOS i/j loop sequencer feeding the two-stage step datapath of one Fp^2 Montgomery half.
// Optional macro FIOS_LOOP_CTRL_PERF_EN adds the busy_cycles counter output.
module fios_loop_ctrl
    import fios_loop_ctrl_pkg::*;
#(
    parameter int RADIX  = 32,
    parameter int WORDS  = 8,
    parameter int IDX_W  = 4,
    parameter int MM_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             op_valid,
    output logic [IDX_W-1:0] a_idx,
    output logic [IDX_W-1:0] b_idx,
    output logic             mm_zero,
    output logic [IDX_W-1:0] t_raddr,
    output logic             carry_zero,
    output logic             d_last,
    output logic             mm_load,
    output logic             t_we,
    output logic [IDX_W-1:0] t_waddr,
    output logic             t_top_we
`ifdef FIOS_LOOP_CTRL_PERF_EN
    ,
    output logic [31:0]      busy_cycles
`endif
);

    localparam int CNT_W    = $clog2(MM_LAT + 2);
    // Gap length is whatever remains of the period after probe, MM wait and issues.
    localparam int GAP_LAST = iter_period(WORDS, MM_LAT) - (WORDS + MM_LAT + 1) - 1;
    localparam logic [IDX_W-1:0] LAST_J = IDX_W'(WORDS - 1);

    if (WORDS < 2 || MM_LAT < 1 || (1 << IDX_W) < WORDS || RADIX < 1) begin : g_param_err
        $error("fios_loop_ctrl: illegal parameter combination");
    end

    state_t           state_q, state_d;
    logic [IDX_W-1:0] i_q, i_d;
    logic [IDX_W-1:0] j_q, j_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             accept;
    logic             probe_st, issue_st;
    logic             we_k;
    logic [IDX_W-1:0] waddr_k;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // The done cycle is spent in IDLE, so start must also wait for done_q to drop.
    assign accept = (state_q == IDLE) && start && !done_q;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = PROBE;
                    i_d     = '0;
                end
            end
            PROBE: begin
                state_d = MMWAIT;
                cnt_d   = '0;
            end
            MMWAIT: begin
                if (cnt_q == CNT_W'(MM_LAT - 1)) begin
                    state_d = ISSUE;
                    j_d     = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ISSUE: begin
                if (j_q == LAST_J) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(GAP_LAST)) begin
                    if (i_q == LAST_J) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = PROBE;
                        i_d     = i_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign probe_st = (state_q == PROBE);
    assign issue_st = (state_q == ISSUE);

    assign op_valid = probe_st | issue_st;
    assign mm_zero  = probe_st;
    assign a_idx    = issue_st ? j_q : '0;
    assign t_raddr  = issue_st ? j_q : '0;
    assign b_idx    = op_valid ? i_q : '0;
    assign busy     = (state_q != IDLE) | done_q;
    assign done     = done_q;

    // The sum of the real j=0 step has no home; only j>=1 writes t[j-1].
    assign we_k    = issue_st && (j_q != '0);
    assign waddr_k = we_k ? (j_q - 1'b1) : '0;

    fios_ctrl_delay #(
        .IDX_W(IDX_W)
    ) u_delay (
        .clk          (clk),
        .rst          (rst),
        .mm_load_k    (probe_st),
        .carry_zero_k (probe_st | (issue_st && (j_q == '0))),
        .d_last_k     (issue_st && (j_q == LAST_J)),
        .we_k         (we_k),
        .waddr_k      (waddr_k),
        .top_we_k     (issue_st && (j_q == LAST_J)),
        .mm_load      (mm_load),
        .carry_zero   (carry_zero),
        .d_last       (d_last),
        .t_we         (t_we),
        .t_waddr      (t_waddr),
        .t_top_we     (t_top_we)
    );

`ifdef FIOS_LOOP_CTRL_PERF_EN
    logic [31:0] busy_cycles_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cycles_q <= '0;
        end else if (accept) begin
            busy_cycles_q <= '0;
        end else if (busy) begin
            busy_cycles_q <= busy_cycles_q + 32'd1;
        end
    end

    assign busy_cycles = busy_cycles_q;
`endif

endmodule

// File: tb/tb_fios_loop_ctrl.sv
// Scoreboard bench: two sequencer configurations driven by shared start/rst stimulus.
module tb_fios_loop_ctrl;
    import fios_loop_ctrl_pkg::*;

    localparam int NDUT = 2;
    localparam int W0 = 4, L0 = 1;
    localparam int W1 = 2, L1 = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    always #5 clk = ~clk;

    logic [NDUT-1:0]      busy, done, op_valid, mm_zero, carry_zero, d_last, mm_load, t_we, t_top_we;
    logic [NDUT-1:0][3:0] a_idx, b_idx, t_raddr, t_waddr;
`ifdef FIOS_LOOP_CTRL_PERF_EN
    logic [NDUT-1:0][31:0] busy_cycles;
`endif

    fios_loop_ctrl #(.RADIX(32), .WORDS(W0), .IDX_W(4), .MM_LAT(L0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .busy(busy[0]), .done(done[0]),
        .op_valid(op_valid[0]), .a_idx(a_idx[0]), .b_idx(b_idx[0]), .mm_zero(mm_zero[0]),
        .t_raddr(t_raddr[0]), .carry_zero(carry_zero[0]), .d_last(d_last[0]),
        .mm_load(mm_load[0]), .t_we(t_we[0]), .t_waddr(t_waddr[0]), .t_top_we(t_top_we[0])
`ifdef FIOS_LOOP_CTRL_PERF_EN
        , .busy_cycles(busy_cycles[0])
`endif
    );

    fios_loop_ctrl #(.RADIX(32), .WORDS(W1), .IDX_W(4), .MM_LAT(L1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .busy(busy[1]), .done(done[1]),
        .op_valid(op_valid[1]), .a_idx(a_idx[1]), .b_idx(b_idx[1]), .mm_zero(mm_zero[1]),
        .t_raddr(t_raddr[1]), .carry_zero(carry_zero[1]), .d_last(d_last[1]),
        .mm_load(mm_load[1]), .t_we(t_we[1]), .t_waddr(t_waddr[1]), .t_top_we(t_top_we[1])
`ifdef FIOS_LOOP_CTRL_PERF_EN
        , .busy_cycles(busy_cycles[1])
`endif
    );

    typedef struct {
        int cyc;
        int a;
        int b;
        bit f0;
        bit f1;
        bit f2;
    } ev_t;

    ev_t iss_q [NDUT][$];
    ev_t k1_q  [NDUT][$];
    ev_t wb_q  [NDUT][$];
    ev_t dn_q  [NDUT][$];
    int  busy_lo [NDUT] = '{1, 1};
    int  busy_hi [NDUT] = '{0, 0};
    int  cyc = 0;
    int  checks = 0;
    int  errs = 0;
    bit  end_req = 1'b0;

    function automatic int words_of(input int d);
        return (d == 0) ? W0 : W1;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? L0 : L1;
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s dut%0d cyc %0d: got %0d expected %0d", nm, d, cyc, act, exp);
        end
    endtask

    // Expected event stream of one whole multiplication accepted at cycle s.
    task automatic gen_run(input int d, input int s);
        int w, l, p, t, k;
        ev_t e;
        w = words_of(d);
        l = lat_of(d);
        p = iter_period(w, l);
        for (int i = 0; i < w; i++) begin
            t = s + 1 + i * p;
            e = '{t, 0, i, 1'b1, 1'b0, 1'b0};
            iss_q[d].push_back(e);
            e = '{t + 1, 0, 0, 1'b1, 1'b1, 1'b0};
            k1_q[d].push_back(e);
            for (int j = 0; j < w; j++) begin
                k = t + 1 + l + j;
                e = '{k, j, i, 1'b0, 1'b0, 1'b0};
                iss_q[d].push_back(e);
                if (j == 0 || j == w - 1) begin
                    e = '{k + 1, 0, 0, 1'b0, bit'(j == 0), bit'(j == w - 1)};
                    k1_q[d].push_back(e);
                end
                if (j >= 1) begin
                    e = '{k + 2, j - 1, 0, 1'b1, bit'(j == w - 1), 1'b0};
                    wb_q[d].push_back(e);
                end
            end
        end
        e = '{s + run_latency(w, l), 0, 0, 1'b1, 1'b0, 1'b0};
        dn_q[d].push_back(e);
        busy_lo[d] = s + 1;
        busy_hi[d] = s + run_latency(w, l);
    endtask

    // Reset at cycle r: nothing expected after r survives.
    task automatic flush(input int d, input int r);
        while (iss_q[d].size() > 0 && iss_q[d][$].cyc > r) void'(iss_q[d].pop_back());
        while (k1_q[d].size() > 0 && k1_q[d][$].cyc > r) void'(k1_q[d].pop_back());
        while (wb_q[d].size() > 0 && wb_q[d][$].cyc > r) void'(wb_q[d].pop_back());
        while (dn_q[d].size() > 0 && dn_q[d][$].cyc > r) void'(dn_q[d].pop_back());
        busy_lo[d] = r + 1;
        busy_hi[d] = r;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            for (int d = 0; d < NDUT; d++) begin
                if (rst) flush(d, cyc);
                else if (start && cyc > busy_hi[d]) gen_run(d, cyc);
            end
            cyc = cyc + 1;
        end
    end

    initial begin : monitor
        ev_t e;
        int  hi, ex;
        forever begin
            @(negedge clk);
            if (end_req) begin
                for (int d = 0; d < NDUT; d++) begin
                    chk("leftover_issue", d, 32'(iss_q[d].size()), 32'd0);
                    chk("leftover_k1", d, 32'(k1_q[d].size()), 32'd0);
                    chk("leftover_wb", d, 32'(wb_q[d].size()), 32'd0);
                    chk("leftover_done", d, 32'(dn_q[d].size()), 32'd0);
                end
                $display("CHECKS %0d ERRORS %0d", checks, errs);
                $finish;
            end
            for (int d = 0; d < NDUT; d++) begin
                chk("busy", d, 32'(busy[d]), 32'(cyc >= busy_lo[d] && cyc <= busy_hi[d]));
`ifdef FIOS_LOOP_CTRL_PERF_EN
                hi = (busy_hi[d] < cyc - 1) ? busy_hi[d] : cyc - 1;
                ex = hi - busy_lo[d] + 1;
                if (ex < 0) ex = 0;
                chk("busy_cycles", d, busy_cycles[d], 32'(ex));
`endif
                if (op_valid[d]) begin
                    if (iss_q[d].size() == 0) begin
                        chk("op_valid_unexpected", d, 32'(op_valid[d]), 32'd0);
                    end else begin
                        e = iss_q[d].pop_front();
                        chk("issue_cycle", d, 32'(cyc), 32'(e.cyc));
                        chk("a_idx", d, 32'(a_idx[d]), 32'(e.a));
                        chk("t_raddr", d, 32'(t_raddr[d]), 32'(e.a));
                        chk("b_idx", d, 32'(b_idx[d]), 32'(e.b));
                        chk("mm_zero", d, 32'(mm_zero[d]), 32'(e.f0));
                    end
                    if (t_we[d] || t_top_we[d]) begin
                        chk("same_cycle_rd_wr", d,
                            32'((t_we[d] && t_raddr[d] == t_waddr[d]) ||
                                (t_top_we[d] && int'(t_raddr[d]) == words_of(d) - 1)), 32'd0);
                    end
                end else begin
                    chk("idle_operands", d, 32'({a_idx[d], b_idx[d], t_raddr[d], mm_zero[d]}), 32'd0);
                    if (iss_q[d].size() > 0 && iss_q[d][0].cyc == cyc) begin
                        chk("op_valid_missing", d, 32'(op_valid[d]), 32'd1);
                        void'(iss_q[d].pop_front());
                    end
                end
                if (mm_load[d] || carry_zero[d] || d_last[d]) begin
                    if (k1_q[d].size() == 0) begin
                        chk("k1_unexpected", d, 32'({mm_load[d], carry_zero[d], d_last[d]}), 32'd0);
                    end else begin
                        e = k1_q[d].pop_front();
                        chk("k1_cycle", d, 32'(cyc), 32'(e.cyc));
                        chk("k1_flags", d, 32'({mm_load[d], carry_zero[d], d_last[d]}),
                            32'({e.f0, e.f1, e.f2}));
                    end
                end else if (k1_q[d].size() > 0 && k1_q[d][0].cyc == cyc) begin
                    e = k1_q[d].pop_front();
                    chk("k1_missing", d, 32'({mm_load[d], carry_zero[d], d_last[d]}),
                        32'({e.f0, e.f1, e.f2}));
                end
                if (t_we[d] || t_top_we[d]) begin
                    if (wb_q[d].size() == 0) begin
                        chk("wb_unexpected", d, 32'({t_we[d], t_top_we[d]}), 32'd0);
                    end else begin
                        e = wb_q[d].pop_front();
                        chk("wb_cycle", d, 32'(cyc), 32'(e.cyc));
                        chk("wb_flags", d, 32'({t_we[d], t_top_we[d]}), 32'({e.f0, e.f1}));
                        chk("t_waddr", d, 32'(t_waddr[d]), 32'(e.a));
                    end
                end else if (wb_q[d].size() > 0 && wb_q[d][0].cyc == cyc) begin
                    e = wb_q[d].pop_front();
                    chk("wb_missing", d, 32'({t_we[d], t_top_we[d]}), 32'({e.f0, e.f1}));
                end
                if (done[d]) begin
                    if (dn_q[d].size() == 0) begin
                        chk("done_unexpected", d, 32'(done[d]), 32'd0);
                    end else begin
                        e = dn_q[d].pop_front();
                        chk("done_cycle", d, 32'(cyc), 32'(e.cyc));
                    end
                end else if (dn_q[d].size() > 0 && dn_q[d][0].cyc == cyc) begin
                    void'(dn_q[d].pop_front());
                    chk("done_missing", d, 32'(done[d]), 32'd1);
                end
            end
        end
    end

    task automatic go_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : stimulus
        rst = 1'b1;
        start = 1'b0;
        go_to(4);  rst = 1'b0;
        go_to(10); start = 1'b1;
        go_to(11); start = 1'b0;
        go_to(25); start = 1'b1;
        go_to(26); start = 1'b0;
        // start held high: back-to-back runs only from IDLE after done
        go_to(50);  start = 1'b1;
        go_to(101); start = 1'b0;
        // reset in the middle of an iteration, then a clean run
        go_to(130); start = 1'b1;
        go_to(131); start = 1'b0;
        go_to(143); rst = 1'b1;
        go_to(144); rst = 1'b0;
        go_to(150); start = 1'b1;
        go_to(151); start = 1'b0;
        go_to(200);
        for (int c = 200; c < 1400; c++) begin
            start = ($urandom_range(0, 3) == 0);
            rst   = ($urandom_range(0, 149) == 0);
            go_to(c + 1);
        end
        start = 1'b0;
        rst = 1'b0;
        go_to(1460);
        end_req = 1'b1;
        repeat (5) @(posedge clk);
        $display("FAIL monitor_stall: summary not reached, errors so far %0d", errs);
        $fatal(1);
    end

endmodule
